// File: rtl/password_pkg.sv
// ============================================================================
// Module      : password_pkg
// Description : Shared state encoding, key constants and helpers for the
//               password-entry controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package password_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        CHECK    = 3'd2,
        FAIL     = 3'd3,
        UNLOCKED = 3'd4,
        LOCKED   = 3'd5
    } state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hE;
    localparam logic [3:0] KEY_RELOCK = 4'hF;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    // Low 4*len bits set: the nibbles the shift buffer holds after len digits.
    function automatic logic [15:0] pw_mask(input int len);
        return 16'hFFFF >> (16 - 4 * len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/password_fsm_sec_timer.sv
// ============================================================================
// Module      : sec_timer
// Description : 4-bit loadable seconds down-counter with an expiry pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_timer #(
    parameter logic [3:0] RESET_VAL = 4'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       tick,
    output logic [3:0] count,
    output logic       expire
);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= RESET_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Independent of load so the controller can use it to decide the reload.
    assign expire = tick && (r_count == 4'd1);
    assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/password_fsm.sv
// ============================================================================
// Module      : password_fsm
// Description : Keypad password controller: entry, check, unlock, lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module password_fsm
    import password_pkg::*;
#(
    parameter int          PW_LEN    = 4,
    parameter logic [15:0] PASSWORD  = 16'h1234,
    parameter int          TIMEOUT   = 5,
    parameter int          LOCK_TIME = 5,
    parameter int          MAX_FAIL  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       tick,
    output logic [3:0] count_down,
    output logic [3:0] counter,
    output logic       unlock,
    output logic       alarm
);

    localparam logic [3:0]  c_TIMEOUT   = 4'(TIMEOUT);
    localparam logic [3:0]  c_LOCK_TIME = 4'(LOCK_TIME);
    localparam logic [3:0]  c_MAX_FAIL  = 4'(MAX_FAIL);
    localparam logic [2:0]  c_PW_LEN    = 3'(PW_LEN);
    localparam logic [15:0] c_MASK      = pw_mask(PW_LEN);
    localparam logic [15:0] c_EXPECT    = PASSWORD >> (4 * (4 - PW_LEN));

    state_t      r_state, w_state_nxt;
    logic [15:0] r_buf, w_buf_nxt;
    logic [2:0]  r_dcnt, w_dcnt_nxt;
    logic [3:0]  r_counter, w_counter_nxt;
    logic        r_unlock, w_unlock_nxt;
    logic        r_alarm, w_alarm_nxt;

    logic        w_load;
    logic [3:0]  w_load_val;
    logic        w_tick_en;
    logic        w_expire;
    logic        w_digit, w_clear, w_relock;
    logic [2:0]  w_dcnt_inc;
    logic [3:0]  w_cnt_sat;

    assign w_digit    = key_valid && (key_code <= DIGIT_MAX);
    assign w_clear    = key_valid && (key_code == KEY_CLEAR);
    assign w_relock   = key_valid && (key_code == KEY_RELOCK);
    assign w_dcnt_inc = r_dcnt + 3'd1;
    assign w_cnt_sat  = (r_counter == 4'hF) ? 4'hF : r_counter + 4'd1;
    // IDLE holds the window at TIMEOUT by simply not counting ticks.
    assign w_tick_en  = tick && ((r_state == ENTRY) || (r_state == UNLOCKED) ||
                                 (r_state == LOCKED));

    sec_timer #(
        .RESET_VAL (c_TIMEOUT)
    ) u_sec_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (w_tick_en),
        .count    (count_down),
        .expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_buf     <= 16'h0;
            r_dcnt    <= 3'd0;
            r_counter <= 4'd0;
            r_unlock  <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_buf     <= w_buf_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_counter <= w_counter_nxt;
            r_unlock  <= w_unlock_nxt;
            r_alarm   <= w_alarm_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_dcnt_nxt    = r_dcnt;
        w_counter_nxt = r_counter;
        w_unlock_nxt  = r_unlock;
        w_alarm_nxt   = r_alarm;
        w_load        = 1'b0;
        w_load_val    = c_TIMEOUT;

        case (r_state)
            IDLE: begin
                if (w_digit) begin
                    w_buf_nxt   = {r_buf[11:0], key_code};
                    w_dcnt_nxt  = 3'd1;
                    w_state_nxt = (c_PW_LEN == 3'd1) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                // A key reload takes priority over a same-cycle tick.
                if (w_digit) begin
                    w_buf_nxt  = {r_buf[11:0], key_code};
                    w_dcnt_nxt = w_dcnt_inc;
                    w_load     = 1'b1;
                    if (w_dcnt_inc == c_PW_LEN) begin
                        w_state_nxt = CHECK;
                    end
                end else if (w_clear) begin
                    w_buf_nxt  = 16'h0;
                    w_dcnt_nxt = 3'd0;
                    w_load     = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt = FAIL;
                end
            end
            CHECK: begin
                if ((r_buf & c_MASK) == c_EXPECT) begin
                    w_counter_nxt = 4'd0;
                    w_unlock_nxt  = 1'b1;
                    w_buf_nxt     = 16'h0;
                    w_dcnt_nxt    = 3'd0;
                    w_load        = 1'b1;
                    w_state_nxt   = UNLOCKED;
                end else begin
                    w_state_nxt = FAIL;
                end
            end
            FAIL: begin
                w_counter_nxt = w_cnt_sat;
                w_buf_nxt     = 16'h0;
                w_dcnt_nxt    = 3'd0;
                w_load        = 1'b1;
                if (w_cnt_sat >= c_MAX_FAIL) begin
                    w_load_val  = c_LOCK_TIME;
                    w_alarm_nxt = 1'b1;
                    w_state_nxt = LOCKED;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            UNLOCKED: begin
                if (w_relock || w_expire) begin
                    w_unlock_nxt = 1'b0;
                    w_load       = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            LOCKED: begin
                if (w_expire) begin
                    w_alarm_nxt   = 1'b0;
                    w_counter_nxt = 4'd0;
                    w_load        = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign counter = r_counter;
    assign unlock  = r_unlock;
    assign alarm   = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_password_fsm.sv
// ============================================================================
// Module      : tb_password_fsm
// Description : Directed self-checking bench for password_fsm (default params).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_password_fsm;
    import password_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       tick = 1'b0;
    logic [3:0] count_down;
    logic [3:0] counter;
    logic       unlock;
    logic       alarm;

    int r_tests = 0;
    int r_fails = 0;

    password_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .tick       (tick),
        .count_down (count_down),
        .counter    (counter),
        .unlock     (unlock),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic kv, input logic [3:0] kc, input logic tk);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        tick      = tk;
        @(negedge clk);
        key_valid = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        drive(1'b1, k, 1'b0);
    endtask

    task automatic do_tick();
        drive(1'b0, 4'h0, 1'b1);
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cd",     16'(count_down), 16'd5);
        check("rst_cnt",    16'(counter),    16'd0);
        check("rst_unlock", 16'(unlock),     16'd0);
        check("rst_alarm",  16'(alarm),      16'd0);
        check("rst_state",  16'(dut.r_state), 16'(IDLE));
        rst = 1'b1;

        // Correct password: unlock two edges after the final digit
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("ul_lat1", 16'(unlock), 16'd0);
        @(negedge clk);
        check("ul_unlock", 16'(unlock),     16'd1);
        check("ul_cd",     16'(count_down), 16'd5);
        check("ul_cnt",    16'(counter),    16'd0);
        for (int i = 4; i >= 1; i--) begin
            do_tick();
            check("ul_tick_cd", 16'(count_down), 16'(i));
        end
        do_tick();
        check("ul_exp_unlock", 16'(unlock),      16'd0);
        check("ul_exp_cd",     16'(count_down),  16'd5);
        check("ul_exp_state",  16'(dut.r_state), 16'(IDLE));

        // Three wrong attempts lead to lockout
        for (int r = 1; r <= 3; r++) begin
            enter4(4'd1, 4'd2, 4'd3, 4'd5);
            @(negedge clk);
            check("wr_cnt_pre", 16'(counter), 16'(r - 1));
            @(negedge clk);
            check("wr_cnt", 16'(counter),    16'(r));
            check("wr_cd",  16'(count_down), 16'd5);
            check("wr_alarm", 16'(alarm), (r == 3) ? 16'd1 : 16'd0);
        end
        check("lk_state", 16'(dut.r_state), 16'(LOCKED));
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        press(KEY_RELOCK);
        check("lk_keys_state", 16'(dut.r_state), 16'(LOCKED));
        check("lk_keys_cd",    16'(count_down),  16'd5);
        check("lk_keys_unl",   16'(unlock),      16'd0);
        repeat (4) do_tick();
        check("lk_cd1", 16'(count_down), 16'd1);
        do_tick();
        check("lk_exp_alarm", 16'(alarm),      16'd0);
        check("lk_exp_cnt",   16'(counter),    16'd0);
        check("lk_exp_cd",    16'(count_down), 16'd5);

        // Entry timeout counts as a failure
        press(4'd1);
        check("to_state", 16'(dut.r_state), 16'(ENTRY));
        for (int i = 4; i >= 0; i--) begin
            do_tick();
            check("to_cd", 16'(count_down), 16'(i));
        end
        check("to_fail_state", 16'(dut.r_state), 16'(FAIL));
        @(negedge clk);
        check("to_cnt",   16'(counter),     16'd1);
        check("to_cd5",   16'(count_down),  16'd5);
        check("to_state", 16'(dut.r_state), 16'(IDLE));

        // Ignored keys, clear, then a good entry
        press(4'hA);
        press(4'hB);
        check("ab_state", 16'(dut.r_state), 16'(IDLE));
        press(4'd9);
        press(4'd9);
        press(KEY_CLEAR);
        check("clr_state", 16'(dut.r_state), 16'(ENTRY));
        check("clr_dcnt",  16'(dut.r_dcnt),  16'd0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        check("clr_unlock", 16'(unlock),  16'd1);
        check("clr_cnt",    16'(counter), 16'd0);

        // Relock from UNLOCKED with count_down = 3
        do_tick();
        do_tick();
        check("rl_cd3", 16'(count_down), 16'd3);
        press(KEY_RELOCK);
        check("rl_state",  16'(dut.r_state), 16'(IDLE));
        check("rl_unlock", 16'(unlock),      16'd0);
        check("rl_cd",     16'(count_down),  16'd5);

        // Key and tick in the same cycle: the reload wins
        press(4'd1);
        do_tick();
        check("kt_cd4", 16'(count_down), 16'd4);
        drive(1'b1, 4'd2, 1'b1);
        check("kt_cd", 16'(count_down), 16'd5);
        press(4'd3);
        press(4'd4);
        @(negedge clk);
        check("kt_unlock", 16'(unlock), 16'd1);
        press(KEY_RELOCK);

        // Asynchronous reset during lockout
        for (int r = 0; r < 3; r++) begin
            enter4(4'd1, 4'd2, 4'd3, 4'd5);
            repeat (2) @(negedge clk);
        end
        check("ar_alarm_pre", 16'(alarm), 16'd1);
        do_tick();
        check("ar_cd_pre", 16'(count_down), 16'd4);
        #2 rst = 1'b0;
        #1;
        check("ar_cd",     16'(count_down),  16'd5);
        check("ar_cnt",    16'(counter),     16'd0);
        check("ar_alarm",  16'(alarm),       16'd0);
        check("ar_unlock", 16'(unlock),      16'd0);
        check("ar_state",  16'(dut.r_state), 16'(IDLE));
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule

`default_nettype wire
